// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo
//   Single-clock synchronous FIFO with registered status flags, sticky error
//   flags and a selectable read mode (registered read or first-word-fall-
//   through).
//
// Parameters
//   DATA_W    width of data_in / data_out
//   DEPTH     number of entries (power of two, >= 4)
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//   FWFT      0 = data_out loads on an accepted pop,
//             1 = data_out always shows the head word while not empty
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   data_in       write data
//   push          write request
//   full          count == DEPTH
//   data_out      read data
//   pop           read request
//   empty         count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         number of stored entries
//   overflow      sticky: a push was rejected
//   underflow     sticky: a pop was rejected
//   clr_err       synchronous clear of overflow/underflow (a new rejection
//                 in the same cycle wins)
//
// Handshake: push is accepted in a cycle iff push=1 and full=0; pop is
// accepted iff pop=1 and empty=0. Both decisions use only registered flags,
// so there is no combinational path from push/pop to any status output.
// -----------------------------------------------------------------------------
module param_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       push,
    output logic                       full,
    output logic [DATA_W-1:0]          data_out,
    input  logic                       pop,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Storage is deliberately not reset; data_out is the only path out of it
    // and is itself reset, so stale words never become visible.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nxt;
    logic [CW-1:0]     count_nxt;
    logic              push_ok;
    logic              pop_ok;
    logic              fall_through;
    logic [DATA_W-1:0] data_nxt;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // In FWFT mode the incoming word becomes the head in the same edge when
    // nothing else will remain stored after this cycle's pop.
    assign fall_through = push_ok &&
                          ((count == '0) || ((count == CW'(1)) && pop_ok));

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    assign rd_ptr_nxt = pop_ok ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        data_nxt = data_out;
        if (FWFT != 0) begin
            if (fall_through) begin
                data_nxt = data_in;
            end else if (count_nxt != '0) begin
                data_nxt = mem[rd_ptr_nxt];
            end
        end else if (pop_ok) begin
            data_nxt = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            data_out     <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            // Flags are decoded from the next count so they line up with
            // count in the same cycle while still coming from flops.
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
            // A rejection in the same cycle as clr_err keeps the flag set.
            overflow     <= (push & full) | (overflow & ~clr_err);
            underflow    <= (pop & empty) | (underflow & ~clr_err);
            data_out     <= data_nxt;
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_fifo
//   Drives two param_fifo instances (DEPTH=4) with identical stimulus: one in
//   registered-read mode, one in first-word-fall-through mode with different
//   almost thresholds. A queue-based reference model tracks contents and
//   sticky flags; a monitor compares status and data after every edge.
// -----------------------------------------------------------------------------
module tb_param_fifo;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int CW  = 3;
    localparam int AF0 = D - 2;
    localparam int AE0 = 2;
    localparam int AF1 = 3;
    localparam int AE1 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] data_in = '0;
    logic         push    = 1'b0;
    logic         pop     = 1'b0;
    logic         clr_err = 1'b0;

    logic          full0, empty0, af0, ae0, ov0, un0;
    logic [CW-1:0] count0;
    logic [W-1:0]  dout0;
    logic          full1, empty1, af1, ae1, ov1, un1;
    logic [CW-1:0] count1;
    logic [W-1:0]  dout1;

    param_fifo #(.DATA_W(W), .DEPTH(D), .AF_LEVEL(AF0), .AE_LEVEL(AE0), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .data_in(data_in), .push(push), .full(full0),
        .data_out(dout0), .pop(pop), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(count0), .overflow(ov0), .underflow(un0),
        .clr_err(clr_err)
    );

    param_fifo #(.DATA_W(W), .DEPTH(D), .AF_LEVEL(AF1), .AE_LEVEL(AE1), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .data_in(data_in), .push(push), .full(full1),
        .data_out(dout1), .pop(pop), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(count1), .overflow(ov1), .underflow(un1),
        .clr_err(clr_err)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0] model_q[$];
    logic [W-1:0] exp_q[$];
    logic         m_ov  = 1'b0;
    logic         m_un  = 1'b0;
    logic [W-1:0] last0 = '0;
    logic [W-1:0] last1 = '0;
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // {full, empty, almost_full, almost_empty, overflow, underflow, count}
    function automatic logic [8:0] exp_stat(input int af, input int ae);
        int n;
        n = model_q.size();
        return {n == D, n == 0, n >= af, n <= ae, m_ov, m_un, 3'(n)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic p, input logic q, input logic [W-1:0] d, input logic c);
        bit acc_push;
        bit acc_pop;
        logic [W-1:0] head;
        @(negedge clk);
        push = p; pop = q; data_in = d; clr_err = c;
        acc_push = p && (model_q.size() < D);
        acc_pop  = q && (model_q.size() > 0);
        @(posedge clk);
        if (acc_pop) begin
            head = model_q.pop_front();
            exp_q.push_back(head);
        end
        if (acc_push) model_q.push_back(d);
        if (p && !acc_push) m_ov = 1'b1;
        else if (c)         m_ov = 1'b0;
        if (q && !acc_pop)  m_un = 1'b1;
        else if (c)         m_un = 1'b0;
        if (model_q.size() > 0) last1 = model_q[0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        #2 rst = 1'b0;
        model_q.delete();
        exp_q.delete();
        m_ov = 1'b0; m_un = 1'b0; last0 = '0; last1 = '0;
        #1;
        // Checked before any clock edge: reset must act asynchronously.
        check("async_rst_stat0", {full0, empty0, af0, ae0, ov0, un0, count0}, exp_stat(AF0, AE0));
        check("async_rst_stat1", {full1, empty1, af1, ae1, ov1, un1, count1}, exp_stat(AF1, AE1));
        check("async_rst_dout0", dout0, '0);
        check("async_rst_dout1", dout1, '0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always begin
        @(posedge clk);
        #2;
        check("stat_reg",  {full0, empty0, af0, ae0, ov0, un0, count0}, exp_stat(AF0, AE0));
        check("stat_fwft", {full1, empty1, af1, ae1, ov1, un1, count1}, exp_stat(AF1, AE1));
        if (exp_q.size() > 0) last0 = exp_q.pop_front();
        check("dout_reg",  dout0, last0);
        check("dout_fwft", dout1, last1);
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Fill to full, then drain in order.
        for (int i = 0; i < D; i++) drive(1'b1, 1'b0, 8'hA1 + 8'(i), 1'b0);
        for (int i = 0; i < D; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Full FIFO with push+pop: pop only, overflow sets; then clear it.
        for (int i = 0; i < D; i++) drive(1'b1, 1'b0, 8'hB0 + 8'(i), 1'b0);
        drive(1'b1, 1'b1, 8'hEE, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // Drain, then push+pop on empty: push only, underflow sets.
        for (int i = 0; i < D - 1; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'h3C, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 8'h00, 1'b0);

        // Fall-through of a single word into an empty FIFO, no pop.
        drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);

        // Clear with a simultaneous rejection: set wins.
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // Random interleaving across many pointer wraps.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
        end

        // Bring to count=3, reset mid-transfer, then first push is first pop.
        for (int i = 0; i < 2 * D && model_q.size() > 0; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0);
        do_reset();
        drive(1'b1, 1'b0, 8'h7E, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
